// File: rtl/cpu_stack_sequencer_if.sv
// Command, memory and register-file write-back signals of the stack sequencer.
interface cpu_stack_sequencer_if;
    // command from the decoder, with the register values it applies to
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  a_in;
    logic [7:0]  sp_in;
    logic [7:0]  ps_in;
    logic [15:0] pc_in;
    logic [15:0] target_in;

    // memory port; read data is returned the cycle after mem_re
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    // register-file write side
    logic        we_a;
    logic        we_sp;
    logic        we_pc;
    logic        we_ps;
    logic [7:0]  data_out;
    logic [7:0]  flags_out;
    logic [15:0] pc_out;
    logic        busy;
    logic        done;

    // decoder / memory / register-file side
    modport master (
        output cmd_valid, cmd_op, a_in, sp_in, ps_in, pc_in, target_in, mem_rdata,
        input  cmd_ready, mem_addr, mem_wdata, mem_we, mem_re,
               we_a, we_sp, we_pc, we_ps, data_out, flags_out, pc_out, busy, done
    );

    // the sequencer
    modport slave (
        input  cmd_valid, cmd_op, a_in, sp_in, ps_in, pc_in, target_in, mem_rdata,
        output cmd_ready, mem_addr, mem_wdata, mem_we, mem_re,
               we_a, we_sp, we_pc, we_ps, data_out, flags_out, pc_out, busy, done
    );
endinterface

// File: rtl/cpu_stack_sequencer.sv
// Stack-class operation sequencer: runs the page-1 push/pull transfers for
// PHA/PHP/PLA/PLP/JSR/RTS/BRK/RTI and writes the results back to the
// register file in dedicated write-back cycles.
module cpu_stack_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_stack_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        OP_PHA = 3'd0,
        OP_PHP = 3'd1,
        OP_PLA = 3'd2,
        OP_PLP = 3'd3,
        OP_JSR = 3'd4,
        OP_RTS = 3'd5,
        OP_BRK = 3'd6,
        OP_RTI = 3'd7
    } op_e;

    // A pull is two states: issue the read, then capture the byte.
    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH,
        S_PULL_RD,
        S_PULL_CAP,
        S_VEC_RD,
        S_VEC_CAP,
        S_WB,
        S_WB_SP,
        S_WB_A
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [7:0]  a;
        logic [7:0]  ps;
        logic [15:0] pc;
        logic [15:0] target;
    } cmd_t;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;   // index of the push/pull/vector byte within the op
    cmd_t        cmd_q;
    logic [7:0]  sp_q;             // working stack pointer
    logic [7:0]  byte_q;           // pulled A (PLA) or pulled PS (PLP/RTI)
    logic [7:0]  lo_q, hi_q;       // pulled return address or vector bytes

    op_e         new_op;
    logic        new_is_push;
    logic [1:0]  last_step;
    logic [15:0] ret_addr;
    logic [7:0]  push_data;
    logic [7:0]  sp_inc;

    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        we_a, we_sp, we_pc, we_ps;
    logic [7:0]  data_out;
    logic [7:0]  flags_out;
    logic [15:0] pc_out;
    logic        done;

    assign new_op   = op_e'(bus.cmd_op);
    assign ret_addr = cmd_q.pc - 16'd1;
    assign sp_inc   = sp_q + 8'd1;

    // Per-op shape: whether it starts with pushes, and the last push/pull index.
    always_comb begin
        new_is_push = 1'b0;
        case (new_op)
            OP_PHA, OP_PHP, OP_JSR, OP_BRK: new_is_push = 1'b1;
            default:                        new_is_push = 1'b0;
        endcase
        last_step = 2'd0;
        case (cmd_q.op)
            OP_JSR, OP_RTS: last_step = 2'd1;
            OP_BRK, OP_RTI: last_step = 2'd2;
            default:        last_step = 2'd0;
        endcase
    end

    // Byte pushed in the current push step; B and bit 5 are forced set on pushed PS.
    always_comb begin
        push_data = 8'h00;
        case (cmd_q.op)
            OP_PHA: push_data = cmd_q.a;
            OP_PHP: push_data = cmd_q.ps | 8'h30;
            OP_JSR: push_data = (step_q == 2'd0) ? ret_addr[15:8] : ret_addr[7:0];
            OP_BRK: begin
                case (step_q)
                    2'd0:    push_data = cmd_q.pc[15:8];
                    2'd1:    push_data = cmd_q.pc[7:0];
                    default: push_data = cmd_q.ps | 8'h30;
                endcase
            end
            default: push_data = 8'h00;
        endcase
    end

    // State and step register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Command latch, stack pointer tracking and pulled-byte capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q  <= '0;
            sp_q   <= 8'h00;
            byte_q <= 8'h00;
            lo_q   <= 8'h00;
            hi_q   <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q.op     <= new_op;
                        cmd_q.a      <= bus.a_in;
                        cmd_q.ps     <= bus.ps_in;
                        cmd_q.pc     <= bus.pc_in;
                        cmd_q.target <= bus.target_in;
                        sp_q         <= bus.sp_in;
                    end
                end
                S_PUSH:    sp_q <= sp_q - 8'd1;
                S_PULL_RD: sp_q <= sp_inc;
                S_PULL_CAP: begin
                    case (cmd_q.op)
                        OP_RTS: begin
                            if (step_q == 2'd0) lo_q <= bus.mem_rdata;
                            else                hi_q <= bus.mem_rdata;
                        end
                        OP_RTI: begin
                            case (step_q)
                                2'd0:    byte_q <= bus.mem_rdata;
                                2'd1:    lo_q   <= bus.mem_rdata;
                                default: hi_q   <= bus.mem_rdata;
                            endcase
                        end
                        default: byte_q <= bus.mem_rdata;
                    endcase
                end
                S_VEC_CAP: begin
                    if (step_q[0]) hi_q <= bus.mem_rdata;
                    else           lo_q <= bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Next-state sequencing plus memory strobes and write-back outputs.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        we_a      = 1'b0;
        we_sp     = 1'b0;
        we_pc     = 1'b0;
        we_ps     = 1'b0;
        data_out  = 8'h00;
        flags_out = 8'h00;
        pc_out    = 16'h0000;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    step_d  = 2'd0;
                    state_d = new_is_push ? S_PUSH : S_PULL_RD;
                end
            end
            S_PUSH: begin
                mem_addr  = {STACK_PAGE, sp_q};
                mem_wdata = push_data;
                mem_we    = 1'b1;
                if (step_q == last_step) begin
                    step_d  = 2'd0;
                    state_d = (cmd_q.op == OP_BRK) ? S_VEC_RD : S_WB;
                end else begin
                    step_d  = step_q + 2'd1;
                end
            end
            S_PULL_RD: begin
                mem_addr = {STACK_PAGE, sp_inc};
                mem_re   = 1'b1;
                state_d  = S_PULL_CAP;
            end
            S_PULL_CAP: begin
                if (step_q == last_step) begin
                    step_d  = 2'd0;
                    state_d = (cmd_q.op == OP_PLA) ? S_WB_SP : S_WB;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = S_PULL_RD;
                end
            end
            S_VEC_RD: begin
                // vector fetch leaves sp alone
                mem_addr = IRQ_VEC + {15'd0, step_q[0]};
                mem_re   = 1'b1;
                state_d  = S_VEC_CAP;
            end
            S_VEC_CAP: begin
                if (step_q[0]) begin
                    step_d  = 2'd0;
                    state_d = S_WB;
                end else begin
                    step_d  = 2'd1;
                    state_d = S_VEC_RD;
                end
            end
            S_WB: begin
                done     = 1'b1;
                we_sp    = 1'b1;
                data_out = sp_q;
                case (cmd_q.op)
                    OP_PLP: begin
                        we_ps     = 1'b1;
                        flags_out = (byte_q & 8'hCF) | 8'h20;
                    end
                    OP_RTI: begin
                        we_ps     = 1'b1;
                        flags_out = (byte_q & 8'hCF) | 8'h20;
                        we_pc     = 1'b1;
                        pc_out    = {hi_q, lo_q};
                    end
                    OP_BRK: begin
                        we_ps     = 1'b1;
                        flags_out = cmd_q.ps | 8'h04;
                        we_pc     = 1'b1;
                        pc_out    = {hi_q, lo_q};
                    end
                    OP_JSR: begin
                        we_pc  = 1'b1;
                        pc_out = cmd_q.target;
                    end
                    OP_RTS: begin
                        we_pc  = 1'b1;
                        pc_out = {hi_q, lo_q} + 16'd1;
                    end
                    default: ;
                endcase
                state_d = S_IDLE;
            end
            // PLA writes SP and A on separate cycles so the shared bus has one target
            S_WB_SP: begin
                we_sp    = 1'b1;
                data_out = sp_q;
                state_d  = S_WB_A;
            end
            S_WB_A: begin
                we_a     = 1'b1;
                data_out = byte_q;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_we    = mem_we;
    assign bus.mem_re    = mem_re;
    assign bus.we_a      = we_a;
    assign bus.we_sp     = we_sp;
    assign bus.we_pc     = we_pc;
    assign bus.we_ps     = we_ps;
    assign bus.data_out  = data_out;
    assign bus.flags_out = flags_out;
    assign bus.pc_out    = pc_out;
    assign bus.done      = done;

endmodule

// File: tb/tb_cpu_stack_sequencer.sv
// Bench for cpu_stack_sequencer: directed scenarios followed by random
// command streams, each checked against a transaction-level stack model.
module tb_cpu_stack_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu_stack_sequencer_if bus();

    cpu_stack_sequencer #(.STACK_PAGE(8'h01), .IRQ_VEC(16'hFFFE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic [7:0]  mem     [0:65535];   // memory seen by the DUT
    logic [7:0]  ref_mem [0:65535];   // model's own copy
    acc_t        exp_q [$];
    logic [7:0]  m_sp;
    logic [7:0]  exp_sp, exp_a, exp_ps;
    logic [15:0] exp_pc;
    bit          exp_we_a, exp_we_ps, exp_we_pc;
    logic [7:0]  seen_sp, seen_a, seen_ps;
    logic [15:0] seen_pc;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat_tab [8] = '{2, 2, 4, 3, 3, 5, 8, 7};

    // memory returns read data the cycle after mem_re
    always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, expv);
        end
    endtask

    // one cycle; DUT writes land in memory mid-cycle
    task automatic tick();
        @(negedge clk);
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    endtask

    task automatic set_mem(input logic [15:0] addr, input logic [7:0] d);
        mem[addr]     = d;
        ref_mem[addr] = d;
    endtask

    task automatic m_push(input logic [7:0] d);
        acc_t e;
        e.we = 1'b1; e.addr = {8'h01, m_sp}; e.data = d;
        exp_q.push_back(e);
        ref_mem[{8'h01, m_sp}] = d;
        m_sp = m_sp - 8'd1;
    endtask

    task automatic m_read(input logic [15:0] addr, output logic [7:0] v);
        acc_t e;
        e.we = 1'b0; e.addr = addr; e.data = 8'h00;
        exp_q.push_back(e);
        v = ref_mem[addr];
    endtask

    task automatic m_pull(output logic [7:0] v);
        m_sp = m_sp + 8'd1;
        m_read({8'h01, m_sp}, v);
    endtask

    // Stack semantics of each op: byte traffic and resulting registers.
    task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] sp,
                         input logic [7:0] ps, input logic [15:0] pc, input logic [15:0] tgt);
        logic [7:0]  v, lo, hi;
        logic [15:0] ret;
        exp_q.delete();
        m_sp = sp;
        exp_we_a = 0; exp_we_ps = 0; exp_we_pc = 0;
        exp_a = 8'h00; exp_ps = 8'h00; exp_pc = 16'h0000;
        case (op)
            3'd0: m_push(a);
            3'd1: m_push(ps | 8'h30);
            3'd2: begin m_pull(v); exp_we_a = 1; exp_a = v; end
            3'd3: begin m_pull(v); exp_we_ps = 1; exp_ps = (v & 8'hCF) | 8'h20; end
            3'd4: begin
                ret = pc - 16'd1;
                m_push(ret[15:8]); m_push(ret[7:0]);
                exp_we_pc = 1; exp_pc = tgt;
            end
            3'd5: begin
                m_pull(lo); m_pull(hi);
                exp_we_pc = 1; exp_pc = {hi, lo} + 16'd1;
            end
            3'd6: begin
                m_push(pc[15:8]); m_push(pc[7:0]); m_push(ps | 8'h30);
                m_read(16'hFFFE, lo); m_read(16'hFFFF, hi);
                exp_we_ps = 1; exp_ps = ps | 8'h04;
                exp_we_pc = 1; exp_pc = {hi, lo};
            end
            default: begin
                m_pull(v); m_pull(lo); m_pull(hi);
                exp_we_ps = 1; exp_ps = (v & 8'hCF) | 8'h20;
                exp_we_pc = 1; exp_pc = {hi, lo};
            end
        endcase
        exp_sp = m_sp;
    endtask

    // Issue one command (optionally holding cmd_valid while busy) and check it all.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] sp,
                           input logic [7:0] ps, input logic [15:0] pc, input logic [15:0] tgt,
                           input bit spam);
        int lat, n_acc, done_cyc, done_cnt, sp_cnt, a_cnt, ps_cnt, pc_cnt, dbl, dbl_bus;
        acc_t e;
        model(op, a, sp, ps, pc, tgt);
        lat = lat_tab[op];
        n_acc = 0; done_cyc = 0; done_cnt = 0; sp_cnt = 0; a_cnt = 0;
        ps_cnt = 0; pc_cnt = 0; dbl = 0; dbl_bus = 0;
        seen_sp = 8'h00; seen_a = 8'h00; seen_ps = 8'h00; seen_pc = 16'h0000;

        chk("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_op = op; bus.a_in = a; bus.sp_in = sp; bus.ps_in = ps;
        bus.pc_in = pc; bus.target_in = tgt; bus.cmd_valid = 1'b1;
        tick();
        for (int c = 1; c <= lat + 3; c++) begin
            bus.cmd_valid = spam && (c < lat);
            bus.cmd_op    = 3'd0;
            if (c == 1)       chk("busy_cycle1", 32'(bus.busy), 32'd1);
            if (c == lat + 1) chk("ready_after_done", {31'd0, bus.cmd_ready}, 32'd1);
            if (bus.mem_we && bus.mem_re) dbl++;
            if (bus.mem_we || bus.mem_re) begin
                if (n_acc < exp_q.size()) begin
                    e = exp_q[n_acc];
                    chk("mem_access",
                        {7'd0, bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00},
                        {7'd0, e.we, e.addr, e.we ? e.data : 8'h00});
                end
                n_acc++;
            end
            if (bus.we_a && bus.we_sp) dbl_bus++;
            if (bus.we_sp) begin sp_cnt++; seen_sp = bus.data_out; end
            if (bus.we_a)  begin a_cnt++;  seen_a  = bus.data_out; end
            if (bus.we_ps) begin ps_cnt++; seen_ps = bus.flags_out; end
            if (bus.we_pc) begin pc_cnt++; seen_pc = bus.pc_out; end
            if (bus.done) begin
                if (done_cnt == 0) done_cyc = c;
                done_cnt++;
            end
            tick();
        end
        chk("access_count", 32'(n_acc), 32'(exp_q.size()));
        chk("one_strobe", 32'(dbl), 32'd0);
        chk("bus_one_target", 32'(dbl_bus), 32'd0);
        chk("done_cycle", 32'(done_cyc), 32'(lat));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("we_sp_pulses", 32'(sp_cnt), 32'd1);
        chk("wb_sp", 32'(seen_sp), 32'(exp_sp));
        chk("we_a_pulses", 32'(a_cnt), 32'(exp_we_a));
        chk("we_ps_pulses", 32'(ps_cnt), 32'(exp_we_ps));
        chk("we_pc_pulses", 32'(pc_cnt), 32'(exp_we_pc));
        if (exp_we_a)  chk("wb_a", 32'(seen_a), 32'(exp_a));
        if (exp_we_ps) chk("wb_ps", 32'(seen_ps), 32'(exp_ps));
        if (exp_we_pc) chk("wb_pc", 32'(seen_pc), 32'(exp_pc));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_strobes"},
            32'({bus.we_a, bus.we_sp, bus.we_pc, bus.we_ps, bus.done, bus.busy, bus.mem_we, bus.mem_re}),
            32'd0);
        chk({tag, "_addr_wdata"}, {8'd0, bus.mem_addr, bus.mem_wdata}, 32'd0);
        chk({tag, "_buses"}, {bus.data_out, bus.flags_out, bus.pc_out}, 32'd0);
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        logic [7:0]  r_a, r_sp, r_ps;
        logic [15:0] r_pc;
        logic [7:0]  bnd [4];
        int          quiet;

        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.a_in = 8'h00; bus.sp_in = 8'h00;
        bus.ps_in = 8'h00; bus.pc_in = 16'h0000; bus.target_in = 16'h0000;
        for (int i = 16'h0100; i <= 16'h01FF; i++) set_mem(16'(i), 8'($urandom));
        set_mem(16'hFFFE, 8'h00);
        set_mem(16'hFFFF, 8'h80);
        repeat (3) tick();
        reset = 1'b0;
        chk_idle_zero("reset");

        // PHA
        run_cmd(3'd0, 8'h5A, 8'hFD, 8'h00, 16'h0000, 16'h0000, 1'b0);
        chk("pha_mem_01FD", 32'(mem[16'h01FD]), 32'h5A);
        chk("pha_sp", 32'(seen_sp), 32'hFC);

        // PLA from the top of the page wraps sp to 00
        set_mem(16'h0100, 8'h77);
        run_cmd(3'd2, 8'h00, 8'hFF, 8'h00, 16'h0000, 16'h0000, 1'b0);
        chk("pla_a", 32'(seen_a), 32'h77);
        chk("pla_sp", 32'(seen_sp), 32'h00);

        // JSR then RTS
        run_cmd(3'd4, 8'h00, 8'hFD, 8'h00, 16'h1002, 16'h2000, 1'b0);
        chk("jsr_mem", {16'd0, mem[16'h01FD], mem[16'h01FC]}, 32'h1001);
        chk("jsr_pc", 32'(seen_pc), 32'h2000);
        chk("jsr_sp", 32'(seen_sp), 32'hFB);
        run_cmd(3'd5, 8'h00, 8'hFB, 8'h00, 16'h2000, 16'h0000, 1'b0);
        chk("rts_pc", 32'(seen_pc), 32'h1002);
        chk("rts_sp", 32'(seen_sp), 32'hFD);

        // BRK then RTI
        run_cmd(3'd6, 8'h00, 8'hFD, 8'h20, 16'h1234, 16'h0000, 1'b0);
        chk("brk_stack", {8'd0, mem[16'h01FD], mem[16'h01FC], mem[16'h01FB]}, 32'h123430);
        chk("brk_ps", 32'(seen_ps), 32'h24);
        chk("brk_pc", 32'(seen_pc), 32'h8000);
        chk("brk_sp", 32'(seen_sp), 32'hFA);
        set_mem(16'h01FB, 8'hFF);
        run_cmd(3'd7, 8'h00, 8'hFA, 8'h00, 16'h8000, 16'h0000, 1'b0);
        chk("rti_ps", 32'(seen_ps), 32'hEF);
        chk("rti_pc", 32'(seen_pc), 32'h1234);
        chk("rti_sp", 32'(seen_sp), 32'hFD);

        // reset during BRK's third push aborts everything
        bus.cmd_op = 3'd6; bus.a_in = 8'h00; bus.sp_in = 8'hFD; bus.ps_in = 8'h20;
        bus.pc_in = 16'h4567; bus.target_in = 16'h0000; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("brk_c3_push", {15'd0, bus.mem_we, bus.mem_addr}, 32'h101FB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_zero("midop_reset");
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_we || bus.mem_re || bus.we_a || bus.we_sp || bus.we_pc || bus.we_ps || bus.done)
                quiet++;
            tick();
        end
        chk("no_activity_after_reset", 32'(quiet), 32'd0);
        set_mem(16'h01FB, 8'h11);
        set_mem(16'h01FC, 8'h22);
        set_mem(16'h01FD, 8'h33);

        // cmd_valid held while busy is ignored
        run_cmd(3'd6, 8'h00, 8'h02, 8'hC3, 16'hABCD, 16'h0000, 1'b1);
        run_cmd(3'd1, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b1);

        // random command stream, register state carried by the model
        bnd = '{8'h00, 8'h01, 8'hFE, 8'hFF};
        r_a = 8'($urandom); r_sp = 8'hFD; r_ps = 8'($urandom); r_pc = 16'($urandom);
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op;
            logic [15:0] tgt;
            op  = 3'($urandom_range(0, 7));
            tgt = 16'($urandom);
            if ($urandom_range(0, 4) == 0) r_sp = bnd[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) r_pc = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
            if ($urandom_range(0, 3) == 0) r_a  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r_ps = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                set_mem(16'hFFFE, 8'($urandom));
                set_mem(16'hFFFF, 8'($urandom));
            end
            run_cmd(op, r_a, r_sp, r_ps, r_pc, tgt, $urandom_range(0, 3) == 0);
            r_sp = exp_sp;
            if (exp_we_a)  r_a  = exp_a;
            if (exp_we_ps) r_ps = exp_ps;
            if (exp_we_pc) r_pc = exp_pc;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
